// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the 4-bit opcode values presented on alu_ctrl and the FSM state
// encoding, so the datapath and anything driving it agree on both.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_DIV  = 4'b1110;
  localparam logic [3:0] OP_MULT = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle of the sequential ALU.
//   start, alu_ctrl, data_1, data_2 : request side (driven by the master)
//   busy, done                      : status
//   alu_result, result_hi, zero,
//   div_by_zero                     : results, valid while done is high and
//                                     held until the next completion
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] data_1;
  logic [WIDTH-1:0] data_2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output start, alu_ctrl, data_1, data_2,
    input  busy, done, alu_result, result_hi, zero, div_by_zero
  );

  modport slave (
    input  start, alu_ctrl, data_1, data_2,
    output busy, done, alu_result, result_hi, zero, div_by_zero
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) / restoring divide datapath.
// One result bit per step; WIDTH steps per operation.
//   load / load_div : capture operands; load_div selects divide mode
//   a, b            : operand A (multiplicand/dividend), B (multiplier/divisor)
//   step            : advance one iteration
//   last            : the current step is the final one
//   step_lo/step_hi : value the lo/hi registers take after the current step;
//                     on the final step this is {product} or {rem, quot}
module seq_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             load_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] step_lo,
  output logic [WIDTH-1:0] step_hi
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  // mult: hi = partial product, lo = multiplier shifting out, op = multiplicand
  // div : hi = partial remainder, lo = dividend in / quotient out, op = divisor
  logic [WIDTH-1:0] hi_reg, lo_reg, op_reg;
  logic             is_div_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_fits;

  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, op_reg} : '0);
    // Remainder may briefly need WIDTH+1 bits after the shift.
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, op_reg};
    div_fits  = (div_shift >= {1'b0, op_reg});
    if (is_div_reg) begin
      step_hi = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {lo_reg[WIDTH-2:0], div_fits};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  assign last = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg     <= '0;
      lo_reg     <= '0;
      op_reg     <= '0;
      is_div_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (load) begin
      hi_reg     <= '0;
      lo_reg     <= load_div ? a : b;
      op_reg     <= load_div ? b : a;
      is_div_reg <= load_div;
      cnt_reg    <= '0;
    end else if (step) begin
      hi_reg  <= step_hi;
      lo_reg  <= step_lo;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative
// unsigned multiply and divide.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : request/result bundle (slave side), see seq_alu_if
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);
  state_t           state_reg;
  logic [WIDTH-1:0] alu_result_reg, result_hi_reg;
  logic             zero_reg, div_by_zero_reg;

  logic [WIDTH-1:0] sc_result;
  logic             accept, md_load, md_step, md_last;
  logic [WIDTH-1:0] md_lo, md_hi;

  always_comb begin
    sc_result = '0;
    case (bus.alu_ctrl)
      OP_ADD:  sc_result = bus.data_1 + bus.data_2;
      OP_SUB:  sc_result = bus.data_1 - bus.data_2;
      OP_AND:  sc_result = bus.data_1 & bus.data_2;
      OP_OR:   sc_result = bus.data_1 | bus.data_2;
      OP_NOR:  sc_result = ~(bus.data_1 | bus.data_2);
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(bus.data_1) < $signed(bus.data_2)};
      default: sc_result = '0;
    endcase
  end

  assign accept  = (state_reg == ST_IDLE) && bus.start;
  // Divide by zero short-circuits, so the datapath is only loaded for real work.
  assign md_load = accept && ((bus.alu_ctrl == OP_MULT) ||
                              (bus.alu_ctrl == OP_DIV && bus.data_2 != '0));
  assign md_step = (state_reg == ST_MUL) || (state_reg == ST_DIV);

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .load     (md_load),
    .load_div (bus.alu_ctrl == OP_DIV),
    .a        (bus.data_1),
    .b        (bus.data_2),
    .step     (md_step),
    .last     (md_last),
    .step_lo  (md_lo),
    .step_hi  (md_hi)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      alu_result_reg  <= '0;
      result_hi_reg   <= '0;
      zero_reg        <= 1'b1;
      div_by_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.alu_ctrl == OP_MULT) begin
              state_reg <= ST_MUL;
            end else if (bus.alu_ctrl == OP_DIV && bus.data_2 != '0) begin
              state_reg <= ST_DIV;
            end else if (bus.alu_ctrl == OP_DIV) begin
              state_reg       <= ST_DONE;
              alu_result_reg  <= '1;
              result_hi_reg   <= bus.data_1;
              zero_reg        <= 1'b0;
              div_by_zero_reg <= 1'b1;
            end else begin
              state_reg       <= ST_DONE;
              alu_result_reg  <= sc_result;
              result_hi_reg   <= '0;
              zero_reg        <= (sc_result == '0);
              div_by_zero_reg <= 1'b0;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          // Results are taken from the final step's next-state values so
          // completion lands on the same edge as the last iteration.
          if (md_last) begin
            state_reg       <= ST_DONE;
            alu_result_reg  <= md_lo;
            result_hi_reg   <= md_hi;
            zero_reg        <= (md_lo == '0);
            div_by_zero_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state_reg != ST_IDLE);
  assign bus.done        = (state_reg == ST_DONE);
  assign bus.alu_result  = alu_result_reg;
  assign bus.result_hi   = result_hi_reg;
  assign bus.zero        = zero_reg;
  assign bus.div_by_zero = div_by_zero_reg;
endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus ();

  seq_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "/busy"}, 64'(bus.busy), 64'd0);
    check({tag, "/done"}, 64'(bus.done), 64'd0);
    check({tag, "/res"},  64'(bus.alu_result), 64'd0);
    check({tag, "/hi"},   64'(bus.result_hi), 64'd0);
    check({tag, "/zero"}, 64'(bus.zero), 64'd1);
    check({tag, "/dbz"},  64'(bus.div_by_zero), 64'd0);
  endtask

  // Issue one op, scramble the operand inputs after acceptance, wait for
  // done (bounded), check latency/results, and check done is a 1-cycle pulse.
  task automatic do_op(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] exp_lo,
                       input logic [31:0] exp_hi, input logic exp_zero,
                       input logic exp_dbz);
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctrl = op; bus.data_1 = a; bus.data_2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.data_1 = 32'hDEAD_BEEF; bus.data_2 = 32'h1234_5678;
    bus.alu_ctrl = OP_ADD;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op %s ctrl=%b a=0x%0h b=0x%0h -> lat=%0d res=0x%0h hi=0x%0h zero=%0b dbz=%0b",
             tag, op, a, b, lat, bus.alu_result, bus.result_hi, bus.zero, bus.div_by_zero);
    check({tag, "/lat"},  64'(lat), 64'(exp_lat));
    check({tag, "/res"},  64'(bus.alu_result), 64'(exp_lo));
    check({tag, "/hi"},   64'(bus.result_hi), 64'(exp_hi));
    check({tag, "/zero"}, 64'(bus.zero), 64'(exp_zero));
    check({tag, "/dbz"},  64'(bus.div_by_zero), 64'(exp_dbz));
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
    check({tag, "/hold"}, 64'(bus.alu_result), 64'(exp_lo));
  endtask

  initial begin
    int  lat;
    logic seen;
    bus.start = 1'b0; bus.alu_ctrl = 4'b0000; bus.data_1 = '0; bus.data_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;

    //         tag         op        a             b             lat lo            hi            z  dbz
    do_op("add3_5",   OP_ADD,  32'd3,        32'd5,        1,  32'd8,        32'd0,        0, 0);
    do_op("sub3_5",   OP_SUB,  32'd3,        32'd5,        1,  32'hFFFFFFFE, 32'd0,        0, 0);
    do_op("slt3_5",   OP_SLT,  32'd3,        32'd5,        1,  32'd1,        32'd0,        0, 0);
    do_op("slt_neg",  OP_SLT,  32'hFFFFFFFF, 32'd1,        1,  32'd1,        32'd0,        0, 0);
    do_op("slt5_3",   OP_SLT,  32'd5,        32'd3,        1,  32'd0,        32'd0,        1, 0);
    do_op("sub5_5",   OP_SUB,  32'd5,        32'd5,        1,  32'd0,        32'd0,        1, 0);
    do_op("nor0_0",   OP_NOR,  32'd0,        32'd0,        1,  32'hFFFFFFFF, 32'd0,        0, 0);
    do_op("and",      OP_AND,  32'hF0F0,     32'hFF00,     1,  32'hF000,     32'd0,        0, 0);
    do_op("or",       OP_OR,   32'hF0F0,     32'hFF00,     1,  32'hFFF0,     32'd0,        0, 0);
    do_op("add_wrap", OP_ADD,  32'hFFFFFFFF, 32'd2,        1,  32'd1,        32'd0,        0, 0);
    do_op("mul3_5",   OP_MULT, 32'd3,        32'd5,        33, 32'd15,       32'd0,        0, 0);
    do_op("mul_max",  OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'd1,        32'hFFFFFFFE, 0, 0);
    do_op("mul_2e32", OP_MULT, 32'h10000,    32'h10000,    33, 32'd0,        32'd1,        1, 0);
    do_op("div17_5",  OP_DIV,  32'd17,       32'd5,        33, 32'd3,        32'd2,        0, 0);
    do_op("div100_7", OP_DIV,  32'd100,      32'd7,        33, 32'd14,       32'd2,        0, 0);
    do_op("div17_0",  OP_DIV,  32'd17,       32'd0,        1,  32'hFFFFFFFF, 32'd17,       0, 1);
    do_op("undef",    4'b0011, 32'd9,        32'd4,        1,  32'd0,        32'd0,        1, 0);

    // Start pulsed while a mult is running must be dropped, not queued.
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctrl = OP_MULT; bus.data_1 = 32'd6; bus.data_2 = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (lat == 10) begin
        bus.start = 1'b1; bus.alu_ctrl = OP_ADD; bus.data_1 = 32'd3; bus.data_2 = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    $display("op busy_ignore mult 6*7 with add pulse -> lat=%0d res=0x%0h", lat, bus.alu_result);
    check("busy_ign/lat", 64'(lat), 64'd33);
    check("busy_ign/res", 64'(bus.alu_result), 64'd42);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("busy_ign/no_queue", 64'(seen), 64'd0);

    // Reset in the middle of a divide aborts it without a done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctrl = OP_DIV; bus.data_1 = 32'd17; bus.data_2 = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    $display("op reset_abort div 17/5 -> busy=%0b done=%0b res=0x%0h", bus.busy, bus.done, bus.alu_result);
    check_reset_state("abort");
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    check("abort/no_done", 64'(seen), 64'd0);
    do_op("add_after", OP_ADD, 32'd3, 32'd5, 1, 32'd8, 32'd0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; legal range 8..64.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port start, input, 1: operation request; accepted only when busy=0.
REQ-005 Port alu_ctrl, input, 4: opcode. 0010 add, 0110 sub, 0000 and, 0001 or, 1100 nor, 0111 slt, 1111 mult, 1110 div.
REQ-006 Port data_1, input, WIDTH: operand A (multiplicand / dividend).
REQ-007 Port data_2, input, WIDTH: operand B (multiplier / divisor).
REQ-008 Port busy, output, 1: high from the cycle after an accepted start until done deasserts.
REQ-009 Port done, output, 1: single-cycle pulse when results are valid.
REQ-010 Port alu_result, output, WIDTH: primary result (low product half / quotient).
REQ-011 Port result_hi, output, WIDTH: high product half for mult, remainder for div, 0 otherwise.
REQ-012 Port zero, output, 1: alu_result == 0, updated with alu_result.
REQ-013 Port div_by_zero, output, 1: set on div with data_2 == 0, cleared by any other completed op.

Function
REQ-014 FSM states IDLE, MUL, DIV, DONE; busy = (state != IDLE).
REQ-015 IDLE: start=1 latches data_1, data_2, alu_ctrl on that edge; later input changes have no effect on the running operation.
REQ-016 Single-cycle ops (add, sub, and, or, nor, slt, undefined opcode): IDLE -> DONE; done high the cycle after start is accepted.
REQ-017 add/sub wrap modulo 2^WIDTH; no overflow flag.
REQ-018 slt: signed two's-complement compare; alu_result = 1 if A < B else 0.
REQ-019 Undefined opcode: alu_result = 0, result_hi = 0, zero = 1.
REQ-020 mult: unsigned shift-add, one bit per cycle, IDLE -> MUL for WIDTH cycles -> DONE; done WIDTH+1 cycles after start is accepted; {result_hi, alu_result} = full 2*WIDTH-bit product.
REQ-021 div: unsigned restoring division, one bit per cycle, IDLE -> DIV for WIDTH cycles -> DONE; same latency as mult.
REQ-022 div with data_2 = 0: IDLE -> DONE directly (latency 1), alu_result = all ones, result_hi = data_1, div_by_zero = 1.
REQ-023 DONE lasts exactly one cycle, then IDLE; done = (state == DONE).
REQ-024 start while busy=1, including in DONE, is ignored; no queueing.
REQ-025 Outputs alu_result, result_hi, zero, div_by_zero update only on the edge entering DONE and hold until the next completion.
REQ-026 Iteration counter of width clog2(WIDTH)+1; it must not wrap inside an operation.

Reset
REQ-027 reset=1 forces state IDLE, busy=0, done=0, alu_result=0, result_hi=0, zero=1, div_by_zero=0, counter=0.
REQ-028 Reset takes priority over start and aborts any in-flight mult/div with no done pulse.
REQ-029 The first start is accepted on the first edge at which reset=0.

Structure
REQ-030 Shared package alu_pkg holds the opcode constants (REQ-005) and the FSM state encoding; the datapath and the bench both use it.
REQ-031 One sub-module, seq_alu_muldiv, implements the iterative shift-add / restoring datapath (load, step, count); seq_alu holds the FSM, the single-cycle ops and the output registers.
REQ-032 No multiply or divide operator is used in synthesisable RTL.

Verification (WIDTH=32)
REQ-033 add 3,5 -> done 1 cycle after start, alu_result=8, zero=0; sub 3,5 -> 0xFFFFFFFE; slt 3,5 -> 1; slt 0xFFFFFFFF,1 -> 1.
REQ-034 sub 5,5 -> alu_result=0, zero=1; nor 0,0 -> 0xFFFFFFFF.
REQ-035 mult 3,5 -> done exactly 33 cycles after start, alu_result=15, result_hi=0; mult 0xFFFFFFFF,0xFFFFFFFF -> result_hi=0xFFFFFFFE, alu_result=1.
REQ-036 div 17,5 -> done at 33 cycles, alu_result=3, result_hi=2; div 17,0 -> done at 1 cycle, alu_result=0xFFFFFFFF, result_hi=17, div_by_zero=1.
REQ-037 start for add pulsed 10 cycles into a mult -> ignored; only the mult done appears, with the mult result.
REQ-038 reset asserted 10 cycles into a div -> next cycle busy=0, done=0, all outputs at reset values; a following add 3,5 completes normally.
